// File: rtl/cpu_pkg.sv
// Shared fetch-side constants and types for the pipelined MIPS core.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'b00,
    PCSRC_J    = 2'b01,
    PCSRC_JR   = 2'b10,
    PCSRC_RSVD = 2'b11
  } pcSrcE;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0004;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifIdT;

  // A squashed slot: nop with valid low, so ID ignores it.
  function automatic ifIdT ifIdBubble();
    ifIdT b;
    b.pc4   = 32'h0;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC priority selector: taken branch > stall > jump > jr > sequential.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        idValid,
  input  logic [1:0]  idPcSrc,
  input  logic [31:0] jumpTarget,
  input  logic [31:0] jrTarget,
  input  logic        exBranch,
  input  logic        exBranchCond,
  input  logic [31:0] exBranchTarget,
  output logic [31:0] nextPc,
  output logic        ifIdLoad,
  output logic        ifIdBubble,
  output logic        flushIdEx
);

  logic  branchTaken;
  pcSrcE pcSrc;

  assign branchTaken = exBranch & exBranchCond;
  // A bubble in ID must never redirect, whatever the decoder drives.
  assign pcSrc = idValid ? pcSrcE'(idPcSrc) : PCSRC_SEQ;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    nextPc     = pc + 32'd4;
    ifIdLoad   = 1'b1;
    ifIdBubble = 1'b0;
    flushIdEx  = 1'b0;

    if (branchTaken) begin
      // The branch is older than the stalled ID instruction, so it wins.
      nextPc     = exBranchTarget;
      ifIdBubble = 1'b1;
      flushIdEx  = 1'b1;
    end else if (stall) begin
      nextPc    = pc;
      ifIdLoad  = 1'b0;
      flushIdEx = 1'b1;
    end else begin
      unique case (pcSrc)
        PCSRC_J: begin
          nextPc     = jumpTarget;
          ifIdBubble = 1'b1;
        end
        PCSRC_JR: begin
          nextPc     = jrTarget;
          ifIdBubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC register and IF/ID pipeline register with stall/flush/redirect handling.
// Optional misaligned-fetch trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  id_pcsrc,
  input  logic [31:0] id_jump_target,
  input  logic [31:0] id_jr_target,
  input  logic        ex_branch,
  input  logic        ex_branch_cond,
  input  logic [31:0] ex_branch_target,
  input  logic [31:0] imem_instr,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        flush_id_ex,
  output logic        fetch_exc
);

  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] nextPc;
  logic [31:0] pcLoadValue;
  logic        ifIdLoad;
  logic        ifIdBubbleSel;
  logic        excTake;
  ifIdT        ifId;

  assign pcPlus4 = pc + 32'd4;

  next_pc_mux uNextPcMux (
    .pc            (pc),
    .stall         (stall),
    .idValid       (ifId.valid),
    .idPcSrc       (id_pcsrc),
    .jumpTarget    (id_jump_target),
    .jrTarget      (id_jr_target),
    .exBranch      (ex_branch),
    .exBranchCond  (ex_branch_cond),
    .exBranchTarget(ex_branch_target),
    .nextPc        (nextPc),
    .ifIdLoad      (ifIdLoad),
    .ifIdBubble    (ifIdBubbleSel),
    .flushIdEx     (flush_id_ex)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  // PC stays word-aligned, so only a redirect target can trip this.
  assign excTake     = |nextPc[1:0];
  assign pcLoadValue = excTake ? EXC_VECTOR : nextPc;
  assign imem_addr   = pc;

  logic fetchExcQ;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetchExcQ <= 1'b0;
    else        fetchExcQ <= excTake;
  end
  assign fetch_exc = fetchExcQ;
`else
  logic unusedExcVector;
  assign unusedExcVector = ^EXC_VECTOR;
  assign excTake         = 1'b0;
  assign pcLoadValue     = nextPc;
  assign imem_addr       = {pc[31:2], 2'b00};
  assign fetch_exc       = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_PC;
      ifId <= ifIdBubble();
    end else begin
      pc <= pcLoadValue;
      if (ifIdLoad) begin
        if (ifIdBubbleSel || excTake) ifId <= ifIdBubble();
        else                          ifId <= '{pc4: pcPlus4, instr: imem_instr, valid: 1'b1};
      end
    end
  end

  assign if_id_pc4   = ifId.pc4;
  assign if_id_instr = ifId.instr;
  assign if_id_valid = ifId.valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed-vector bench for fetch_sequencer; instruction memory returns 0xC000_0000 ^ addr.
module tb_fetch_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  id_pcsrc;
  logic [31:0] id_jump_target;
  logic [31:0] id_jr_target;
  logic        ex_branch;
  logic        ex_branch_cond;
  logic [31:0] ex_branch_target;
  logic [31:0] imem_instr;
  logic [31:0] imem_addr;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        flush_id_ex;
  logic        fetch_exc;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .id_pcsrc        (id_pcsrc),
    .id_jump_target  (id_jump_target),
    .id_jr_target    (id_jr_target),
    .ex_branch       (ex_branch),
    .ex_branch_cond  (ex_branch_cond),
    .ex_branch_target(ex_branch_target),
    .imem_instr      (imem_instr),
    .imem_addr       (imem_addr),
    .if_id_pc4       (if_id_pc4),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .flush_id_ex     (flush_id_ex),
    .fetch_exc       (fetch_exc)
  );

  function automatic logic [31:0] memAt(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  assign imem_instr = memAt(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearCtl();
    stall            = 1'b0;
    id_pcsrc         = PCSRC_SEQ;
    id_jump_target   = 32'h0;
    id_jr_target     = 32'h0;
    ex_branch        = 1'b0;
    ex_branch_cond   = 1'b0;
    ex_branch_target = 32'h0;
  endtask

  initial begin
    clearCtl();
    reset = 1'b0;
    repeat (3) step();
    check("rst_addr",  imem_addr,   32'h0);
    check("rst_valid", {31'h0, if_id_valid}, 32'h0);
    check("rst_pc4",   if_id_pc4,   32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_exc",   {31'h0, fetch_exc}, 32'h0);
    check("rst_flush", {31'h0, flush_id_ex}, 32'h0);
    reset = 1'b1;
    #2;
    check("rel_addr",  imem_addr, 32'h0);
    check("rel_valid", {31'h0, if_id_valid}, 32'h0);

    // Sequential fetch 0 -> 16
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("seq_addr%0d", i),  imem_addr,   32'(4 * i));
      check($sformatf("seq_pc4%0d", i),   if_id_pc4,   32'(4 * i));
      check($sformatf("seq_instr%0d", i), if_id_instr, memAt(32'(4 * (i - 1))));
      check($sformatf("seq_valid%0d", i), {31'h0, if_id_valid}, 32'h1);
    end

    // Two-cycle stall at PC=0x10
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("stall_flush%0d", i), {31'h0, flush_id_ex}, 32'h1);
      step();
      check($sformatf("stall_addr%0d", i),  imem_addr,   32'h10);
      check($sformatf("stall_pc4%0d", i),   if_id_pc4,   32'h10);
      check($sformatf("stall_instr%0d", i), if_id_instr, 32'hC000_000C);
    end
    stall = 1'b0;
    step();
    check("resume_addr",  imem_addr,   32'h14);
    check("resume_instr", if_id_instr, 32'hC000_0010);

    // Jump to 0x100 from PC=0x14
    id_pcsrc = PCSRC_J;
    id_jump_target = 32'h0000_0100;
    #1;
    check("j_flush", {31'h0, flush_id_ex}, 32'h0);
    step();
    check("j_addr",  imem_addr,   32'h100);
    check("j_valid", {31'h0, if_id_valid}, 32'h0);
    check("j_instr", if_id_instr, 32'h0);

    // Bubble in ID: decoder redirect must be ignored
    id_jump_target = 32'h0000_0200;
    step();
    check("gate_addr",  imem_addr,   32'h104);
    check("gate_pc4",   if_id_pc4,   32'h104);
    check("gate_instr", if_id_instr, 32'hC000_0100);
    check("gate_valid", {31'h0, if_id_valid}, 32'h1);

    // Taken branch beats concurrent stall and jump
    stall = 1'b1;
    id_jump_target = 32'h0000_0300;
    ex_branch = 1'b1;
    ex_branch_cond = 1'b1;
    ex_branch_target = 32'h40;
    #1;
    check("br_flush", {31'h0, flush_id_ex}, 32'h1);
    step();
    check("br_addr",  imem_addr,   32'h40);
    check("br_valid", {31'h0, if_id_valid}, 32'h0);
    check("br_instr", if_id_instr, 32'h0);

    // Not-taken branch is sequential
    clearCtl();
    ex_branch = 1'b1;
    #1;
    check("nt_flush", {31'h0, flush_id_ex}, 32'h0);
    step();
    check("nt_addr",  imem_addr,   32'h44);
    check("nt_pc4",   if_id_pc4,   32'h44);
    check("nt_instr", if_id_instr, 32'hC000_0040);

    // Misaligned register jump
    clearCtl();
    id_pcsrc = PCSRC_JR;
    id_jr_target = 32'h0000_0102;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    check("jr_addr", imem_addr, 32'h8000_0004);
    check("jr_exc",  {31'h0, fetch_exc}, 32'h1);
`else
    check("jr_addr", imem_addr, 32'h100);
    check("jr_exc",  {31'h0, fetch_exc}, 32'h0);
`endif
    check("jr_valid", {31'h0, if_id_valid}, 32'h0);

    // Branch to the top word, then wrap to zero
    clearCtl();
    ex_branch = 1'b1;
    ex_branch_cond = 1'b1;
    ex_branch_target = 32'hFFFF_FFFC;
    step();
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    check("top_exc",  {31'h0, fetch_exc}, 32'h0);
    clearCtl();
    step();
    check("wrap_addr",  imem_addr,   32'h0);
    check("wrap_pc4",   if_id_pc4,   32'h0);
    check("wrap_instr", if_id_instr, 32'h3FFF_FFFC);

    // Asynchronous reset mid-stall, mid-cycle
    step();
    stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("areset_addr",  imem_addr,   32'h0);
    check("areset_valid", {31'h0, if_id_valid}, 32'h0);
    check("areset_instr", if_id_instr, 32'h0);
    clearCtl();
    step();
    reset = 1'b1;
    step();
    check("post_addr", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
